// File: rtl/toeplitz_unpack.sv
// toeplitz_unpack: buffers L-bit extracted words from the Toeplitz extractor
// in a small FIFO and streams them out LSB-first as W-bit chunks on a
// valid/ready link. Words arriving while the FIFO is full are dropped and
// counted.
module toeplitz_unpack #(
  parameter int L     = 128,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [L-1:0]             q,
  input  logic                     qstrobe,
  output logic [W-1:0]             dout,
  output logic                     dvalid,
  input  logic                     dready,
  input  logic                     clr,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int NCH = L / W;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [KW-1:0] K_LAST   = KW'(NCH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // word FIFO
  logic [L-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;

  // serialiser
  logic [0:0]    state_r;
  logic [L-1:0]  shift_r;
  logic [KW-1:0] k_r;

  // drop reporting
  logic          overflow_r;
  logic [15:0]   drop_cnt_r;

  // per-edge decisions
  logic          hs_s;
  logic          last_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;

  // Decide handshake, pop, push and drop for the coming edge. A pop in the
  // same edge frees a slot, so a push into a full FIFO is still accepted.
  always_comb begin
    hs_s   = 1'b0;
    last_s = 1'b0;
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    hs_s   = (state_r == ST_SEND) && dready;
    last_s = hs_s && (k_r == K_LAST);
    case (state_r)
      ST_IDLE: pop_s = (level_r != '0);
      ST_SEND: pop_s = last_s && (level_r != '0);
      default: pop_s = 1'b0;
    endcase
    if (qstrobe) begin
      if ((level_r != FULL_LVL) || pop_s) begin
        push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // FIFO storage: data only, no reset needed since level_r guards reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= q;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + (AW + 1)'(1);
        2'b01:   level_r <= level_r - (AW + 1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Serialiser: load a word on pop, shift one chunk right per handshake so
  // the current chunk always sits in the low W bits; clear when going idle
  // so dout reads zero while nothing is offered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      k_r     <= '0;
    end else if (pop_s) begin
      state_r <= ST_SEND;
      shift_r <= mem_r[rd_ptr_r];
      k_r     <= '0;
    end else if (last_s) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      k_r     <= '0;
    end else if (hs_s) begin
      shift_r <= shift_r >> W;
      k_r     <= k_r + KW'(1);
    end else begin
      state_r <= state_r;
      shift_r <= shift_r;
      k_r     <= k_r;
    end
  end

  // Sticky overflow and saturating drop counter; clr takes priority over a
  // drop in the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else if (clr) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != 16'hFFFF) begin
        drop_cnt_r <= drop_cnt_r + 16'h0001;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end else begin
      overflow_r <= overflow_r;
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign dout       = shift_r[W-1:0];
  assign dvalid     = (state_r == ST_SEND);
  assign level      = level_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_cnt_r;

endmodule

// File: doc/toeplitz_unpack.md
Name: toeplitz_unpack

Overview:
Downstream consumer of the Toeplitz extractor's output word interface (q, qstrobe).
- Captures each L-bit extracted word on qstrobe into a small word FIFO.
- Serialises each word into W-bit chunks on a valid/ready stream for the host link (UART/USB/FIFO bridge).
- Reports words lost to backpressure via a sticky overflow flag and a saturating drop counter.

Parameters:
L, 128, extracted word width; must equal the extractor's L and be a multiple of W
W, 8, output chunk width
DEPTH, 4, FIFO depth in L-bit words; power of two, >= 2

Ports:
clk  input  1  clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
q  input  L  extracted word; valid only in cycles where qstrobe=1
qstrobe  input  1  one-cycle pulse; capture q this edge
dout  output  W  output chunk
dvalid  output  1  dout valid
dready  input  1  sink accepts dout when dvalid & dready at rising edge
clr  input  1  synchronous clear of overflow and drop_count
overflow  output  1  sticky: at least one word dropped since reset/clr
drop_count  output  16  number of dropped words, saturates at 16'hFFFF
level  output  $clog2(DEPTH)+1  words currently in FIFO (excludes the word in the shifter)

Behaviour:
- Reset (reset_n=0, asynchronous): FIFO empty, level=0, shifter idle, dvalid=0, dout=0, overflow=0, drop_count=0. Any partially sent word is discarded.
- Capture:
  - At an edge with qstrobe=1, q is written to the FIFO tail if level<DEPTH.
  - If level==DEPTH and no FIFO pop occurs at the same edge, the word is dropped: overflow<=1, drop_count increments, saturating.
  - If level==DEPTH and a pop occurs at the same edge, the push is accepted and level stays DEPTH.
- Serialiser FSM, states IDLE and SEND:
  - IDLE: dvalid=0. If level>0 at an edge, pop the head into the shift register, set chunk index k=0, and go to SEND. dvalid=1 from the following cycle.
  - SEND: dvalid=1, dout=word[k*W +: W]. Chunk order is LSB-first: chunk 0 = bits W-1:0.
  - At an edge with dready=1 and k<L/W-1: k<=k+1.
  - At an edge with dready=1 and k==L/W-1:
    - if level>0, pop the next word, k<=0, stay in SEND (no bubble between words);
    - otherwise go to IDLE, dvalid<=0.
  - While dvalid=1 and dready=0, dout and dvalid hold stable. dvalid never drops without a handshake.
- Latency: a word captured at edge t (FIFO empty, shifter idle) is popped at edge t+1. dvalid=1 with chunk 0 in the cycle after edge t+1.
- Capacity before drop: DEPTH words in FIFO plus 1 word in the shifter.
- Simultaneous push and pop at the same edge: level unchanged.
- Simultaneous clr and drop at the same edge: clr wins; overflow=0, drop_count=0.
- level updates registered: it reflects all pushes and pops of the previous edge.
- The qstrobe input is not registered; q is sampled only when qstrobe=1.

Test Plan:
- Reset values: hold reset_n=0 with random q/qstrobe -> dvalid=0, dout=0, level=0, overflow=0, drop_count=0. Release with no qstrobe -> all remain 0.
- Single word, L=128, W=8, dready=1: one qstrobe with q=128'h0F0E0D0C0B0A09080706050403020100 -> 16 consecutive handshakes dout=8'h00,01,...,0F. dvalid first high 2 cycles after the qstrobe edge, then low after the last chunk. level returns to 0.
- Backpressure: same word, dready=0 for 5 cycles after chunk 3 appears -> dout holds 8'h03 with dvalid=1 throughout. The sequence resumes 8'h04...8'h0F with no chunk lost or duplicated.
- Back-to-back words: two qstrobes 1 cycle apart (words A, B), dready=1 -> 32 handshakes on 32 consecutive cycles. Chunk 15 of A is immediately followed by chunk 0 of B, with no dvalid gap.
- Overflow, DEPTH=4: dready=0, issue 7 qstrobes -> after the 7th, level=4, overflow=1, drop_count=2. Then dready=1 -> exactly 5 words (80 chunks) emitted, in capture order. clr pulse -> overflow=0, drop_count=0.
- Reset mid-operation: assert reset_n=0 during chunk 7 of a word with 2 words queued -> dvalid=0 and level=0 immediately (asynchronously). After release, no residual chunks are emitted. A new qstrobe word is sent from chunk 0.
